// File: rtl/fir_pkg.sv
// Shared register map, ap_ctrl bit positions and FSM encodings for the FIR
// control front-end.
package fir_pkg;

  localparam int unsigned AP_CTRL  = 32'h00;
  localparam int unsigned DATA_LEN = 32'h10;
  localparam int unsigned TAP_NUM  = 32'h14;
  localparam int unsigned TAP_BASE = 32'h80;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // True when a byte address falls inside the coefficient window.
  function automatic logic is_tap(input logic [31:0] addr, input int unsigned tap_max);
    return (addr >= TAP_BASE) && (addr < TAP_BASE + 4 * tap_max);
  endfunction

endpackage

// File: rtl/fir_tap_arb.sv
// Single-port tap BRAM mux: the engine owns the port in RUN, AXI-Lite
// coefficient accesses use it otherwise.
module fir_tap_arb #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   eng_own,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   wr_en,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_issued,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A
);

  // NOTE: every output gets a default before the priority chain, otherwise
  // the paths that leave it untouched would infer a latch.
  always_comb begin
    tap_WE = '0;
    tap_EN = 1'b0;
    tap_Di = '0;
    tap_A  = '0;
    if (eng_own) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_A;
    end else if (wr_en) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_Di = wr_data;
      tap_A  = wr_addr;
    end else if (rd_en) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr;
    end
  end

  // Marks the cycle in which tap_Do carries data for an AXI read.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) rd_issued <= 1'b0;
    else             rd_issued <= rd_en && !eng_own && !wr_en;
  end

endmodule

// File: rtl/fir_ctrl.sv
// AXI-Lite register front-end, ap_ctrl block FSM and tap BRAM ownership for
// the FIR engine.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] cfg_data_length,
  output logic [pDATA_WIDTH-1:0] cfg_tap_num,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] TAP_OFS = pADDR_WIDTH'(TAP_BASE);

  logic [1:0]             state;
  logic                   ap_start;
  logic                   aw_rdy;
  logic                   rd_busy;
  logic                   rd_s1;
  logic                   rd_issued;
  logic [pADDR_WIDTH-1:0] rd_addr_q;
  logic [pDATA_WIDTH-1:0] ap_ctrl_word;
  logic [pDATA_WIDTH-1:0] rd_word;

  wire idle    = (state == IDLE);
  wire wr_hs   = aw_rdy && awvalid && wvalid;
  wire ar_hs   = arready && arvalid;
  wire r_beat  = rvalid && rready;
  wire wr_pend = awvalid && wvalid && !aw_rdy;
  wire wr_tap  = wr_hs && idle && is_tap(32'(awaddr), pTAP_MAX);
  wire rd_tap  = ar_hs && idle && is_tap(32'(araddr), pTAP_MAX);

  assign awready = aw_rdy;
  assign wready  = aw_rdy;

  fir_tap_arb #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_arb (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .eng_own    (state == RUN),
    .eng_tap_A  (eng_tap_A),
    .wr_en      (wr_tap),
    .wr_addr    (awaddr - TAP_OFS),
    .wr_data    (wdata),
    .rd_en      (rd_tap),
    .rd_addr    (araddr - TAP_OFS),
    .rd_issued  (rd_issued),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A)
  );

  always_comb begin
    ap_ctrl_word               = '0;
    ap_ctrl_word[AP_START_BIT] = ap_start;
    ap_ctrl_word[AP_DONE_BIT]  = (state == DONE);
    ap_ctrl_word[AP_IDLE_BIT]  = idle;
  end

  // Tap reads not served by the BRAM (engine busy) report all ones.
  always_comb begin
    rd_word = '0;
    if (rd_addr_q == pADDR_WIDTH'(AP_CTRL))       rd_word = ap_ctrl_word;
    else if (rd_addr_q == pADDR_WIDTH'(DATA_LEN)) rd_word = cfg_data_length;
    else if (rd_addr_q == pADDR_WIDTH'(TAP_NUM))  rd_word = cfg_tap_num;
    else if (is_tap(32'(rd_addr_q), pTAP_MAX))    rd_word = rd_issued ? tap_Do : '1;
  end

  // A pending AW+W pair blocks AR acceptance so the write always lands first.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      aw_rdy    <= 1'b0;
      arready   <= 1'b0;
      rd_busy   <= 1'b0;
      rd_s1     <= 1'b0;
      rd_addr_q <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
    end else begin
      aw_rdy  <= wr_pend;
      arready <= arvalid && !arready && !rd_busy && !wr_pend;
      rd_s1   <= ar_hs;
      if (ar_hs) begin
        rd_busy   <= 1'b1;
        rd_addr_q <= araddr;
      end else if (r_beat) begin
        rd_busy <= 1'b0;
      end
      if (rd_s1) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end else if (r_beat) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cfg_data_length <= '0;
      cfg_tap_num     <= '0;
    end else if (wr_hs && idle) begin
      if (awaddr == pADDR_WIDTH'(DATA_LEN))
        cfg_data_length <= wdata;
      else if (awaddr == pADDR_WIDTH'(TAP_NUM))
        cfg_tap_num <= (wdata > pDATA_WIDTH'(pTAP_MAX)) ? pDATA_WIDTH'(pTAP_MAX) : wdata;
    end
  end

  // eng_start rises alongside ap_start and both clear as the FSM enters RUN.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= IDLE;
      ap_start  <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            state    <= RUN;
            ap_start <= 1'b0;
          end else if (wr_hs && awaddr == pADDR_WIDTH'(AP_CTRL) && wdata[AP_START_BIT]) begin
            ap_start  <= 1'b1;
            eng_start <= 1'b1;
          end
        end
        RUN:     if (eng_done) state <= DONE;
        DONE:    if (r_beat && rd_addr_q == pADDR_WIDTH'(AP_CTRL)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Scoreboard bench for fir_ctrl: reads push expected data, a monitor pops
// and compares on every R beat.
module tb_fir_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TM = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic          rvalid, rready = 1'b1;
  logic [DW-1:0] rdata;
  logic          eng_start, eng_done = 1'b0;
  logic [AW-1:0] eng_tap_A = '0;
  logic [DW-1:0] cfg_data_length, cfg_tap_num;
  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [DW-1:0] tap_Di;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Do;

  always #5 axis_clk = ~axis_clk;

  fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAP_MAX(TM)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .eng_start(eng_start), .eng_done(eng_done), .eng_tap_A(eng_tap_A),
    .cfg_data_length(cfg_data_length), .cfg_tap_num(cfg_tap_num),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  logic [DW-1:0] bram [TM];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[6:2]] <= tap_Di;
      tap_Do <= bram[tap_A[6:2]];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(negedge axis_clk) begin
    if (eng_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  always @(negedge axis_clk) begin
    if (axis_rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("rd_%03h", mon_e.addr), rdata, mon_e.data);
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(posedge axis_clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!awready && n < 20);
    if (!awready) check("wr_timeout", 32'd0, 32'd1);
    else last_wr_cyc = cyc;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    int n = 0;
    exp_q.push_back('{a, e});
    @(posedge axis_clk); #1;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!arready && n < 50);
    if (!arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge axis_clk); n++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic pulse_done();
    @(posedge axis_clk); #1 eng_done = 1'b1;
    @(posedge axis_clk); #1 eng_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hs"}, {28'd0, awready, wready, arready, rvalid}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_start_en"}, {27'd0, eng_start, tap_EN, tap_WE[2:0]}, 32'd0);
    check({tag, "_tapA"}, 32'(tap_A), 32'd0);
    check({tag, "_tapDi_we3"}, tap_Di | 32'(tap_WE[3]), 32'd0);
    check({tag, "_cfg_len"}, cfg_data_length, 32'd0);
    check({tag, "_cfg_tap"}, cfg_tap_num, 32'd0);
  endtask

  int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    int s0, aw_c, ar_c, n;
    logic aw_hit, ar_hit;

    repeat (3) @(negedge axis_clk);
    check_all_zero("reset");
    axis_rst_n = 1'b1;

    // Configuration, saturation and read-back
    axi_write(12'h014, 32'd100);
    check("tap_num_sat", cfg_tap_num, 32'd32);
    axi_write(12'h014, 32'd11);
    axi_write(12'h010, 32'd600);
    for (int i = 0; i < 11; i++) axi_write(AW'(12'h080 + 4 * i), 32'(coef[i]));
    check("cfg_tap_num", cfg_tap_num, 32'd11);
    check("cfg_data_length", cfg_data_length, 32'd600);
    axi_read(12'h014, 32'd11);
    axi_read(12'h010, 32'd600);
    for (int i = 0; i < 11; i++) axi_read(AW'(12'h080 + 4 * i), 32'(coef[i]));
    axi_read(12'h000, 32'h4);
    axi_read(12'h020, 32'h0);
    drain();

    // Start: eng_start one cycle after the write handshake
    s0 = start_cnt;
    axi_write(12'h000, 32'h1);
    repeat (3) @(negedge axis_clk);
    check("start_count", 32'(start_cnt - s0), 32'd1);
    check("start_delay", 32'(start_cyc - last_wr_cyc), 32'd1);
    axi_read(12'h000, 32'h0);
    axi_write(12'h084, 32'h55);
    axi_read(12'h084, 32'hFFFF_FFFF);
    drain();

    // Engine owns the BRAM in RUN
    for (int i = 0; i < 8; i++) begin
      @(posedge axis_clk); #1 eng_tap_A = AW'(4 * i + 8);
      @(negedge axis_clk);
      check("run_tapA", 32'(tap_A), 32'(4 * i + 8));
      check("run_en_we", {27'd0, tap_EN, tap_WE}, 32'h10);
    end
    eng_tap_A = '0;

    pulse_done();
    axi_read(12'h000, 32'h2);
    axi_read(12'h000, 32'h4);
    axi_read(12'h084, 32'hFFFF_FFF6);
    drain();
    pulse_done();
    axi_read(12'h000, 32'h4);
    drain();

    s0 = start_cnt;
    axi_write(12'h000, 32'h1);
    repeat (3) @(negedge axis_clk);
    check("start2_count", 32'(start_cnt - s0), 32'd1);
    pulse_done();
    axi_read(12'h000, 32'h2);
    drain();

    // Same-cycle AW+W and AR with a stalled R channel
    exp_q.push_back('{12'h010, 32'd777});
    @(posedge axis_clk); #1;
    awaddr = 12'h010; wdata = 32'd777; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h010; arvalid = 1'b1; rready = 1'b0;
    aw_c = -1; ar_c = -1; n = 0;
    while ((aw_c < 0 || ar_c < 0) && n < 20) begin
      @(negedge axis_clk); n++;
      aw_hit = awready; ar_hit = arready;
      if (aw_hit) aw_c = cyc;
      if (ar_hit) ar_c = cyc;
      @(posedge axis_clk); #1;
      if (aw_hit) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (ar_hit) arvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("wr_before_rd", 32'(aw_c >= 0 && aw_c < ar_c), 32'd1);
    n = 0;
    while (!rvalid && n < 10) begin @(negedge axis_clk); n++; end
    @(posedge axis_clk); #1;
    araddr = 12'h014; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rdata", rdata, 32'd777);
      check("stall_arready", 32'(arready), 32'd0);
    end
    @(posedge axis_clk); #1;
    rready = 1'b1; arvalid = 1'b0;
    drain();
    check("simul_cfg_len", cfg_data_length, 32'd777);
    axi_read(12'h014, 32'd11);
    drain();

    // Asynchronous reset in RUN
    axi_write(12'h000, 32'h1);
    repeat (3) @(negedge axis_clk);
    @(posedge axis_clk); #1 eng_tap_A = 12'h01C;
    @(negedge axis_clk);
    check("pre_rst_tapA", 32'(tap_A), 32'h1C);
    @(posedge axis_clk); #3 axis_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    eng_tap_A = '0;
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axi_read(12'h000, 32'h4);
    axi_read(12'h014, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
